// File: rtl/alu_pkg.sv
// Shared ALU definitions: op encodings (matching the ALU) and datapath widths.
// Used by alu_issue_stage and its register file.
package alu_pkg;

  localparam int DW   = 32;
  localparam int NREG = 32;
  localparam int AW   = 5;

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_ADDI = 4'b0011;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_SLT  = 4'b0111;
  localparam logic [3:0] OP_NOR  = 4'b1100;

endpackage

// File: rtl/alu_issue_stage_reg_file.sv
// reg_file: NREG x DW register file, two asynchronous read ports and one
// synchronous write port. r0 always reads zero and ignores writes.
// Contents clear asynchronously on rst.
module reg_file #(
  parameter int DW   = 32,
  parameter int NREG = 32,
  parameter int AW   = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] i_raddr_a,
  output logic [DW-1:0] o_rdata_a,
  input  logic [AW-1:0] i_raddr_b,
  output logic [DW-1:0] o_rdata_b,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [DW-1:0] i_wdata
);

  logic [DW-1:0] r_mem [NREG];

  // Storage: clear on reset, write on strobe unless targeting r0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) r_mem[i] <= '0;
    end else if (i_we && (i_waddr != '0)) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata_a = (i_raddr_a == '0) ? '0 : r_mem[i_raddr_a];
  assign o_rdata_b = (i_raddr_b == '0) ? '0 : r_mem[i_raddr_b];

endmodule

// File: rtl/alu_issue_stage.sv
// alu_issue_stage: issue stage in front of the ALU. Reads operands from the
// register file, stalls read-after-write hazards with a per-register busy
// scoreboard, and registers the op onto the ALU inputs (1-cycle latency,
// single output register with fire-and-refill).
// Optional feature macro: WB_BYPASS_EN -- forwards a same-cycle writeback to
// the operands so a waiting op can issue during the writeback cycle.
module alu_issue_stage
  import alu_pkg::*;
#(
  parameter int DW   = 32,
  parameter int NREG = 32,
  parameter int AW   = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [3:0]    in_op,
  input  logic [AW-1:0] in_rs,
  input  logic [AW-1:0] in_rt,
  input  logic [AW-1:0] in_rd,
  input  logic [15:0]   in_imm,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] a_data,
  output logic [DW-1:0] b_data,
  output logic [3:0]    alu_op,
  output logic [AW-1:0] out_rd,
  input  logic          wb_en,
  input  logic [AW-1:0] wb_addr,
  input  logic [DW-1:0] wb_data
);

  function automatic logic [DW-1:0] sext16(input logic [15:0] imm);
    return {{(DW-16){imm[15]}}, imm};
  endfunction

  logic [DW-1:0]   w_rdata_a;
  logic [DW-1:0]   w_rdata_b;
  logic [DW-1:0]   w_opa;
  logic [DW-1:0]   w_opb;
  logic            w_is_addi;
  logic            w_fwd_a;
  logic            w_fwd_b;
  logic            w_busy_a;
  logic            w_busy_b;
  logic            w_hazard;
  logic            w_accept;
  logic            w_in_ready;
  logic [NREG-1:0] w_busy_nxt;

  logic            r_out_valid;
  logic [DW-1:0]   r_a_data;
  logic [DW-1:0]   r_b_data;
  logic [3:0]      r_alu_op;
  logic [AW-1:0]   r_out_rd;
  logic [NREG-1:0] r_busy;

  reg_file #(.DW(DW), .NREG(NREG), .AW(AW)) u_reg_file (
    .clk       (clk),
    .rst       (rst),
    .i_raddr_a (in_rs),
    .o_rdata_a (w_rdata_a),
    .i_raddr_b (in_rt),
    .o_rdata_b (w_rdata_b),
    .i_we      (wb_en),
    .i_waddr   (wb_addr),
    .i_wdata   (wb_data)
  );

  // Operand selection and hazard detection, with optional writeback forwarding.
  always_comb begin
    w_is_addi = (in_op == OP_ADDI);
`ifdef WB_BYPASS_EN
    w_fwd_a = wb_en && (wb_addr == in_rs) && (in_rs != '0);
    w_fwd_b = wb_en && (wb_addr == in_rt) && (in_rt != '0);
`else
    w_fwd_a = 1'b0;
    w_fwd_b = 1'b0;
`endif
    w_busy_a   = r_busy[in_rs] & ~w_fwd_a;
    w_busy_b   = r_busy[in_rt] & ~w_fwd_b;
    w_opa      = w_fwd_a ? wb_data : w_rdata_a;
    w_opb      = w_is_addi ? sext16(in_imm) : (w_fwd_b ? wb_data : w_rdata_b);
    w_hazard   = in_valid & (w_busy_a | (w_busy_b & ~w_is_addi));
    w_in_ready = (~r_out_valid | out_ready) & ~w_hazard;
    w_accept   = in_valid & w_in_ready;
  end

  // Scoreboard update: writeback clears, accept sets (set wins on a tie); r0 never busy.
  always_comb begin
    w_busy_nxt = r_busy;
    if (wb_en) w_busy_nxt[wb_addr] = 1'b0;
    if (w_accept && (in_rd != '0)) w_busy_nxt[in_rd] = 1'b1;
    w_busy_nxt[0] = 1'b0;
  end

  // Busy scoreboard register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_busy <= '0;
    else     r_busy <= w_busy_nxt;
  end

  // Output register: load on accept, drop valid once consumed, hold while stalled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_a_data    <= '0;
      r_b_data    <= '0;
      r_alu_op    <= '0;
      r_out_rd    <= '0;
    end else if (w_accept) begin
      r_out_valid <= 1'b1;
      r_a_data    <= w_opa;
      r_b_data    <= w_opb;
      r_alu_op    <= in_op;
      r_out_rd    <= in_rd;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign in_ready  = w_in_ready;
  assign out_valid = r_out_valid;
  assign a_data    = r_a_data;
  assign b_data    = r_b_data;
  assign alu_op    = r_alu_op;
  assign out_rd    = r_out_rd;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed bench for alu_issue_stage with a scoreboard of expected ALU-side
// transactions. Honours WB_BYPASS_EN for the RAW timing step.
module tb_alu_issue_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_op;
  logic [4:0]  in_rs, in_rt, in_rd;
  logic [15:0] in_imm;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] a_data, b_data;
  logic [3:0]  alu_op;
  logic [4:0]  out_rd;
  logic        wb_en;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  op;
    logic [4:0]  rd;
  } exp_t;

  exp_t q[$];
  int   n_pass  = 0;
  int   n_total = 0;

  alu_issue_stage dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_imm(in_imm),
    .out_valid(out_valid), .out_ready(out_ready),
    .a_data(a_data), .b_data(b_data), .alu_op(alu_op), .out_rd(out_rd),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] a, input logic [31:0] b,
                      input logic [3:0] op, input logic [4:0] rd);
    exp_t e;
    e.a = a; e.b = b; e.op = op; e.rd = rd;
    q.push_back(e);
  endtask

  task automatic drive_op(input logic [3:0] op, input logic [4:0] rs, input logic [4:0] rt,
                          input logic [4:0] rd, input logic [15:0] imm);
    in_valid = 1'b1; in_op = op; in_rs = rs; in_rt = rt; in_rd = rd; in_imm = imm;
  endtask

  task automatic drive_wb(input logic [4:0] addr, input logic [31:0] data);
    wb_en = 1'b1; wb_addr = addr; wb_data = data;
  endtask

  // Scoreboard: every handshake on the ALU side must match the oldest expectation.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (q.size() == 0) begin
        chk("sb_unexpected_out", q.size(), 1);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("out_a", a_data, e.a);
        chk("out_b", b_data, e.b);
        chk("out_op", {28'd0, alu_op}, {28'd0, e.op});
        chk("out_rd", {27'd0, out_rd}, {27'd0, e.rd});
      end
    end
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_op = 4'd0; in_rs = 5'd0; in_rt = 5'd0; in_rd = 5'd0;
    in_imm = 16'd0; out_ready = 1'b1; wb_en = 1'b0; wb_addr = 5'd0; wb_data = 32'd0;

    // 1 reset
    #12;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_a", a_data, 32'd0);
    chk("rst_b", b_data, 32'd0);
    chk("rst_op", {28'd0, alu_op}, 32'd0);
    chk("rst_rd", {27'd0, out_rd}, 32'd0);
    rst = 1'b0;
    tick();

    // 2 preload r1=7, r2=5; ADD r3 = r1 + r2
    drive_wb(5'd1, 32'd7); tick();
    drive_wb(5'd2, 32'd5); tick();
    wb_en = 1'b0;
    drive_op(4'b0010, 5'd1, 5'd2, 5'd3, 16'd0); #1;
    chk("add_ready", {31'd0, in_ready}, 32'd1);
    push(32'd7, 32'd5, 4'b0010, 5'd3);
    tick();
    chk("add_out_valid", {31'd0, out_valid}, 32'd1);

    // 3 RAW on r3
    drive_op(4'b0110, 5'd3, 5'd1, 5'd6, 16'd0); #1;
    chk("raw_stall0", {31'd0, in_ready}, 32'd0);
    tick();
    chk("raw_stall1", {31'd0, in_ready}, 32'd0);
    drive_wb(5'd3, 32'd12); #1;
`ifdef WB_BYPASS_EN
    chk("raw_bypass_ready", {31'd0, in_ready}, 32'd1);
    push(32'd12, 32'd7, 4'b0110, 5'd6);
    tick();
    wb_en = 1'b0; in_valid = 1'b0;
`else
    chk("raw_wb_cycle_stall", {31'd0, in_ready}, 32'd0);
    tick();
    wb_en = 1'b0; #1;
    chk("raw_after_wb_ready", {31'd0, in_ready}, 32'd1);
    push(32'd12, 32'd7, 4'b0110, 5'd6);
    tick();
    in_valid = 1'b0;
`endif

    // 4 ADDI ignores busy rt
    drive_op(4'b0001, 5'd1, 5'd1, 5'd2, 16'd0); #1;
    push(32'd7, 32'd7, 4'b0001, 5'd2);
    tick();
    drive_op(4'b0011, 5'd1, 5'd2, 5'd4, 16'hFFFE); #1;
    chk("addi_no_stall", {31'd0, in_ready}, 32'd1);
    push(32'd7, 32'hFFFFFFFE, 4'b0011, 5'd4);
    tick();
    drive_op(4'b0000, 5'd1, 5'd2, 5'd9, 16'd0); #1;
    chk("rt_busy_stall", {31'd0, in_ready}, 32'd0);
    in_valid = 1'b0;
    drive_wb(5'd2, 32'd5); tick();
    drive_wb(5'd4, 32'd5); tick();
    drive_wb(5'd6, 32'd5); tick();
    wb_en = 1'b0;

    // 5 backpressure with a second op pending
    out_ready = 1'b0;
    drive_op(4'b0000, 5'd1, 5'd2, 5'd7, 16'd0); #1;
    push(32'd7, 32'd5, 4'b0000, 5'd7);
    tick();
    drive_op(4'b1100, 5'd2, 5'd1, 5'd8, 16'd0);
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
      chk("bp_valid", {31'd0, out_valid}, 32'd1);
      chk("bp_a", a_data, 32'd7);
      chk("bp_b", b_data, 32'd5);
      chk("bp_rd", {27'd0, out_rd}, 32'd7);
      tick();
    end
    out_ready = 1'b1; #1;
    chk("bp_release_ready", {31'd0, in_ready}, 32'd1);
    push(32'd5, 32'd7, 4'b1100, 5'd8);
    tick();
    in_valid = 1'b0;
    tick();

    // unknown op passes through
    drive_op(4'b1111, 5'd1, 5'd2, 5'd12, 16'd0); #1;
    push(32'd7, 32'd5, 4'b1111, 5'd12);
    tick();
    in_valid = 1'b0;

    // 6 r0 edge cases and set-wins
    drive_wb(5'd0, 32'd99); tick();
    wb_en = 1'b0;
    drive_op(4'b0001, 5'd0, 5'd0, 5'd9, 16'd0); #1;
    push(32'd0, 32'd0, 4'b0001, 5'd9);
    tick();
    drive_op(4'b0010, 5'd1, 5'd1, 5'd0, 16'd0); #1;
    push(32'd14 - 32'd7, 32'd7, 4'b0010, 5'd0);
    tick();
    drive_op(4'b0000, 5'd0, 5'd0, 5'd10, 16'd0); #1;
    chk("r0_never_busy", {31'd0, in_ready}, 32'd1);
    push(32'd0, 32'd0, 4'b0000, 5'd10);
    tick();
    drive_op(4'b0010, 5'd1, 5'd2, 5'd5, 16'd0);
    drive_wb(5'd5, 32'd33); #1;
    chk("set_clear_ready", {31'd0, in_ready}, 32'd1);
    push(32'd7, 32'd5, 4'b0010, 5'd5);
    tick();
    wb_en = 1'b0;
    drive_op(4'b0110, 5'd5, 5'd1, 5'd11, 16'd0); #1;
    chk("set_wins_stall", {31'd0, in_ready}, 32'd0);
    in_valid = 1'b0;
    tick();

    // reset mid-handshake drops the in-flight op
    out_ready = 1'b0;
    drive_op(4'b0001, 5'd1, 5'd2, 5'd13, 16'd0); #1;
    chk("pre_rst_ready", {31'd0, in_ready}, 32'd1);
    tick();
    in_valid = 1'b0;
    chk("pre_rst_valid", {31'd0, out_valid}, 32'd1);
    rst = 1'b1; #1;
    chk("midrst_valid", {31'd0, out_valid}, 32'd0);
    chk("midrst_a", a_data, 32'd0);
    chk("midrst_b", b_data, 32'd0);
    chk("midrst_rd", {27'd0, out_rd}, 32'd0);
    #4;
    rst = 1'b0; out_ready = 1'b1;
    tick();
    drive_op(4'b0110, 5'd5, 5'd1, 5'd14, 16'd0); #1;
    chk("busy_cleared_by_rst", {31'd0, in_ready}, 32'd1);
    push(32'd0, 32'd0, 4'b0110, 5'd14);
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    chk("sb_drained", q.size(), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
